// File: rtl/seg7_pkg.sv
// ============================================================================
// Module  : seg7_pkg
// Purpose : Shared segment codes, FSM state type and decode helpers for the
//           seven-segment digit reader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    // Active-low, bit6 = a .. bit0 = g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCEPT = 2'd2
    } seg7_state_t;

    // Returns {legal, blank, digit[3:0]}; legal and blank both 0 means illegal.
    function automatic logic [5:0] seg_to_bcd(input logic [6:0] pat);
        logic [5:0] res;
        res = 6'b000000;
        case (pat)
            SEG_0:     res = {2'b10, 4'd0};
            SEG_1:     res = {2'b10, 4'd1};
            SEG_2:     res = {2'b10, 4'd2};
            SEG_3:     res = {2'b10, 4'd3};
            SEG_4:     res = {2'b10, 4'd4};
            SEG_5:     res = {2'b10, 4'd5};
            SEG_6:     res = {2'b10, 4'd6};
            SEG_7:     res = {2'b10, 4'd7};
            SEG_8:     res = {2'b10, 4'd8};
            SEG_9:     res = {2'b10, 4'd9};
            SEG_BLANK: res = {2'b01, 4'd0};
            default:   res = 6'b000000;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] bcd_inc_mod10(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_sync_filter.sv
// ============================================================================
// Module  : seg7_sync_filter
// Purpose : Two-flop synchroniser plus stability filter; pulses o_accept for
//           one cycle when a new pattern has been steady long enough.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_sync_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] i_seg,
    output logic [6:0] o_stable_pattern,
    output logic       o_accept
);

    localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);

    logic [6:0]  r_s1;
    logic [6:0]  r_s2;
    logic [6:0]  r_cand;
    logic [6:0]  r_last;
    logic [7:0]  r_cnt;
    seg7_state_t r_state;

    seg7_state_t w_state_nxt;
    logic [6:0]  w_cand_nxt;
    logic [6:0]  w_last_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [7:0]  w_cnt_inc;

    assign w_cnt_inc = r_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1    <= SEG_BLANK;
            r_s2    <= SEG_BLANK;
            r_cand  <= SEG_BLANK;
            r_last  <= SEG_BLANK;
            r_cnt   <= 8'd0;
            r_state <= IDLE;
        end else begin
            r_s1    <= i_seg;
            r_s2    <= r_s1;
            r_cand  <= w_cand_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (r_s2 != r_last) begin
                    w_cand_nxt  = r_s2;
                    w_cnt_nxt   = 8'd1;
                    w_state_nxt = (C_STABLE == 8'd1) ? ACCEPT : SETTLE;
                end
            end
            SETTLE: begin
                if (r_s2 == r_cand) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == C_STABLE) begin
                        w_state_nxt = ACCEPT;
                    end
                end else if (r_s2 == r_last) begin
                    // Glitched back to the already-delivered pattern: nothing new.
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cand_nxt = r_s2;
                    w_cnt_nxt  = 8'd1;
                    if (C_STABLE == 8'd1) begin
                        w_state_nxt = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                w_last_nxt  = r_cand;
                w_cnt_nxt   = 8'd0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_stable_pattern = r_cand;
    assign o_accept         = (r_state == ACCEPT);

endmodule

`default_nettype wire

// File: rtl/seg7_digit_reader.sv
// ============================================================================
// Module  : seg7_digit_reader
// Purpose : Recovers BCD digits from an active-low seven-segment bus and
//           hands them downstream through a one-entry valid/ready buffer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_digit_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int UNDO_DEC      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic       blank_out,
    output logic       err_out
);

    logic [6:0] w_pattern;
    logic       w_accept;
    logic [5:0] w_dec;
    logic       w_legal;
    logic       w_blank;
    logic [3:0] w_digit;
    logic       w_handshake;

    logic [3:0] r_digit;
    logic       r_valid;
    logic       r_blank;
    logic       r_err;

    seg7_sync_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_seg            (seg_in),
        .o_stable_pattern (w_pattern),
        .o_accept         (w_accept)
    );

    assign w_dec       = seg_to_bcd(w_pattern);
    assign w_legal     = w_dec[5];
    assign w_blank     = w_dec[4];
    assign w_digit     = (UNDO_DEC != 0) ? bcd_inc_mod10(w_dec[3:0]) : w_dec[3:0];
    assign w_handshake = r_valid & digit_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digit <= 4'd0;
            r_valid <= 1'b0;
            r_blank <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_legal) begin
                    r_digit <= w_digit;
                    r_valid <= 1'b1;
                    r_blank <= 1'b0;
                    // Undelivered digit being replaced is an overrun.
                    if (r_valid && !digit_ready) begin
                        r_err <= 1'b1;
                    end
                end else if (w_blank) begin
                    r_blank <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign digit_out   = r_digit;
    assign digit_valid = r_valid;
    assign blank_out   = r_blank;
    assign err_out     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_seg7_digit_reader.sv
// ============================================================================
// Module  : tb_seg7_digit_reader
// Purpose : Self-checking bench for seg7_digit_reader (two configurations).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg7_digit_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       digit_ready;
    logic [6:0] seg_in;
    logic [3:0] dout_a, dout_b;
    logic       val_a, val_b, blk_a, blk_b, err_a, err_b;

    always #5 clk = ~clk;

    seg7_digit_reader #(.STABLE_CYCLES(4), .UNDO_DEC(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_out(dout_a),
        .digit_valid(val_a), .digit_ready(digit_ready), .blank_out(blk_a), .err_out(err_a)
    );

    seg7_digit_reader #(.STABLE_CYCLES(1), .UNDO_DEC(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_out(dout_b),
        .digit_valid(val_b), .digit_ready(digit_ready), .blank_out(blk_b), .err_out(err_b)
    );

    localparam logic [6:0] SEG_TAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                            7'b0000000, 7'b0000100};
    localparam int M_STABLE [2] = '{4, 1};
    localparam int M_UNDO   [2] = '{1, 0};

    int errors = 0;
    int checks = 0;

    // Reference model: run-length of synchronised samples per configuration
    logic [6:0] m_s1, m_s2;
    logic [6:0] m_last [2];
    logic [6:0] m_cand [2];
    int         m_run  [2];
    bit         m_pend [2];
    logic [3:0] m_digit[2];
    bit         m_valid[2];
    bit         m_blank[2];
    bit         m_err  [2];

    int         pulses_a;
    logic [3:0] last_a;
    bit         prev_a;

    typedef struct {
        logic [6:0] seg;
        logic [6:0] exp_a;
        logic [6:0] exp_b;
    } vec_t;
    vec_t vecs [12];

    function automatic int decode(input logic [6:0] p);
        if (p == 7'b1111111) return 10;
        for (int i = 0; i < 10; i++) if (SEG_TAB[i] == p) return i;
        return -1;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int d;
            bit pre;
            if (!rst_n) begin
                m_last[k] = 7'b1111111; m_cand[k] = 7'b1111111; m_run[k] = 0; m_pend[k] = 0;
                m_digit[k] = 4'd0; m_valid[k] = 0; m_blank[k] = 1; m_err[k] = 0;
            end else begin
                pre = m_valid[k];
                if (pre && digit_ready) m_valid[k] = 0;
                if (m_pend[k]) begin
                    d = decode(m_cand[k]);
                    m_last[k] = m_cand[k];
                    m_pend[k] = 0;
                    m_run[k]  = 0;
                    if (d >= 0 && d <= 9) begin
                        if (pre && !digit_ready) m_err[k] = 1;
                        m_digit[k] = (M_UNDO[k] != 0) ? 4'((d + 1) % 10) : 4'(d);
                        m_valid[k] = 1;
                        m_blank[k] = 0;
                    end else if (d == 10) begin
                        m_blank[k] = 1;
                    end else begin
                        m_err[k] = 1;
                    end
                end else if (m_s2 == m_last[k]) begin
                    m_run[k] = 0;
                end else if (m_run[k] > 0 && m_s2 == m_cand[k]) begin
                    m_run[k]++;
                end else begin
                    m_cand[k] = m_s2;
                    m_run[k]  = 1;
                end
                if (m_run[k] == M_STABLE[k]) m_pend[k] = 1;
            end
        end
        if (!rst_n) begin
            m_s1 = 7'b1111111;
            m_s2 = 7'b1111111;
        end else begin
            m_s2 = m_s1;
            m_s1 = seg_in;
        end
    endtask

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {valid,digit,blank,err}=%b required=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d required=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_a", {val_a, dout_a, blk_a, err_a}, {m_valid[0], m_digit[0], m_blank[0], m_err[0]});
        check("model_b", {val_b, dout_b, blk_b, err_b}, {m_valid[1], m_digit[1], m_blank[1], m_err[1]});
        if (val_a && !prev_a) begin
            pulses_a++;
            last_a = dout_a;
        end
        prev_a = val_a;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        check("reset_a", {val_a, dout_a, blk_a, err_a}, 7'b0_0000_1_0);
        check("reset_b", {val_b, dout_b, blk_b, err_b}, 7'b0_0000_1_0);
        rst_n = 1'b1;
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) step();
    endtask

    initial begin
        int lat_a, lat_b;
        rst_n       = 1'b0;
        digit_ready = 1'b0;
        seg_in      = 7'b1111111;
        pulses_a    = 0;
        prev_a      = 0;
        last_a      = 4'd0;

        // {seg, expected A (UNDO, 4 cycles), expected B (raw, 1 cycle)} as {valid,digit,blank,err}
        vecs[0]  = '{7'b0000001, 7'b1_0001_0_0, 7'b1_0000_0_0};
        vecs[1]  = '{7'b1001111, 7'b1_0010_0_0, 7'b1_0001_0_0};
        vecs[2]  = '{7'b0010010, 7'b1_0011_0_0, 7'b1_0010_0_0};
        vecs[3]  = '{7'b0000110, 7'b1_0100_0_0, 7'b1_0011_0_0};
        vecs[4]  = '{7'b1001100, 7'b1_0101_0_0, 7'b1_0100_0_0};
        vecs[5]  = '{7'b0100100, 7'b1_0110_0_0, 7'b1_0101_0_0};
        vecs[6]  = '{7'b0100000, 7'b1_0111_0_0, 7'b1_0110_0_0};
        vecs[7]  = '{7'b0001111, 7'b1_1000_0_0, 7'b1_0111_0_0};
        vecs[8]  = '{7'b0000000, 7'b1_1001_0_0, 7'b1_1000_0_0};
        vecs[9]  = '{7'b0000100, 7'b1_0000_0_0, 7'b1_1001_0_0};
        vecs[10] = '{7'b1111111, 7'b0_0000_1_0, 7'b0_0000_1_0};
        vecs[11] = '{7'b1110000, 7'b0_0000_1_1, 7'b0_0000_1_1};

        for (int i = 0; i < 12; i++) begin
            do_reset();
            digit_ready = 1'b0;
            hold(vecs[i].seg, 10);
            check($sformatf("table_a[%0d]", i), {val_a, dout_a, blk_a, err_a}, vecs[i].exp_a);
            check($sformatf("table_b[%0d]", i), {val_b, dout_b, blk_b, err_b}, vecs[i].exp_b);
        end

        // Latency: 2 sync + STABLE + 1
        do_reset();
        digit_ready = 1'b1;
        seg_in      = 7'b0100000;
        lat_a = 99;
        lat_b = 99;
        for (int c = 1; c <= 20 && lat_a == 99; c++) begin
            step();
            if (val_b && lat_b == 99) lat_b = c;
            if (val_a) begin
                lat_a = c;
                check_int("digit_6_a", int'(dout_a), 7);
            end
        end
        check_int("latency_a", lat_a, 7);
        check_int("latency_b", lat_b, 4);
        step();
        check_int("valid_drop_a", int'(val_a), 0);

        // Bouncing between two digits, then settling
        do_reset();
        digit_ready = 1'b1;
        pulses_a    = 0;
        for (int i = 0; i < 5; i++) begin
            hold(7'b0000001, 2);
            hold(7'b1001111, 2);
        end
        hold(7'b1001111, 12);
        check_int("bounce_pulses", pulses_a, 1);
        check_int("bounce_value", int'(last_a), 2);
        check_int("bounce_err", int'(err_a), 0);

        // Blank, illegal, then a legal digit with the sticky error
        pulses_a = 0;
        hold(7'b1111111, 10);
        check_int("blank_flag", int'(blk_a), 1);
        check_int("blank_no_pulse", pulses_a, 0);
        hold(7'b1110000, 10);
        check_int("illegal_err", int'(err_a), 1);
        hold(7'b0000110, 10);
        check("sticky_err", {val_a, dout_a, blk_a, err_a}, 7'b0_0100_0_1);

        // Overrun with consumer stalled
        do_reset();
        digit_ready = 1'b0;
        hold(7'b0000110, 10);
        hold(7'b0100100, 10);
        check("overrun", {val_a, dout_a, blk_a, err_a}, 7'b1_0110_0_1);

        // Reset while settling on 8
        do_reset();
        digit_ready = 1'b1;
        hold(7'b0000000, 4);
        rst_n = 1'b0;
        step();
        check("mid_settle_reset", {val_a, dout_a, blk_a, err_a}, 7'b0_0000_1_0);
        rst_n    = 1'b1;
        pulses_a = 0;
        hold(7'b0000000, 14);
        check_int("post_reset_pulses", pulses_a, 1);
        check_int("post_reset_value", int'(last_a), 9);

        // Randomised traffic against the model
        do_reset();
        for (int s = 0; s < 300; s++) begin
            int r;
            int n;
            r = $urandom_range(0, 99);
            if (r < 70)      seg_in = SEG_TAB[$urandom_range(0, 9)];
            else if (r < 82) seg_in = 7'b1111111;
            else             seg_in = 7'($urandom);
            n = $urandom_range(1, 9);
            for (int c = 0; c < n; c++) begin
                digit_ready = 1'($urandom_range(0, 1));
                rst_n       = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
                step();
            end
        end
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
